sync_rx_decoder: RTL
====================

# sync_rx_decoder

Receive-side counterpart of the game synchronisation byte stream. Consumes bytes delivered by the UART receiver from the opponent board and validates the 8-bit sync code. It maintains link state, producing `connect_corrected` for the game state controller, and decodes the opponent's click and game-start events into single-cycle pulses and levels. Sits between the UART RX and `game_state_sel` / match logic in MULTI mode.

## Interface
- `TIMEOUT_CYCLES`, default 2_000_000: cycles without a valid byte before the link is declared lost.
- `LOCK_COUNT`, default 4: consecutive valid bytes needed to declare the link up.
- `ERR_LIMIT`, default 3: consecutive invalid bytes that drop an up link.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: byte from the UART receiver.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid this cycle.
- `connect_corrected`  out  1: link up (state CONNECTED).
- `enemy_left_clicked`  out  1: one-cycle pulse, opponent left click.
- `enemy_right_clicked`  out  1: one-cycle pulse, opponent right click.
- `enemy_game_starts`  out  1: level, opponent asserting game start.
- `frame_error`  out  1: one-cycle pulse on each invalid byte.
- `last_valid_byte`  out  8: most recent valid code.

## Operation
- Valid codes (all others invalid):
  - 8'hC8 = LEFT
  - 8'h28 = RIGHT
  - 8'h48 = START
  - 8'h08 = IDLE
- Link FSM states: DISCONNECTED, SYNCING, CONNECTED.
  - DISCONNECTED: a valid byte goes to SYNCING with lock_cnt=1. Invalid bytes stay.
  - SYNCING: a valid byte increments lock_cnt; on reaching LOCK_COUNT go to CONNECTED. An invalid byte clears lock_cnt and goes to DISCONNECTED.
  - CONNECTED: a valid byte clears err_cnt. An invalid byte increments err_cnt; on reaching ERR_LIMIT go to DISCONNECTED.
  - Timeout in any non-DISCONNECTED state goes to DISCONNECTED.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1); cleared on every valid byte, otherwise increments and saturates.
  - Timeout fires when the count equals TIMEOUT_CYCLES-1.
- Decode applies only to valid bytes received while already in CONNECTED. The byte completing the lock is not decoded.
  - LEFT pulses `enemy_left_clicked`.
  - RIGHT pulses `enemy_right_clicked`.
  - START sets `enemy_game_starts`.
  - IDLE, LEFT and RIGHT clear `enemy_game_starts`.
- Invalid bytes do not change the decode outputs or `last_valid_byte`.
- On leaving CONNECTED, `enemy_game_starts` clears in the same cycle as `connect_corrected`.

## Timing
- All outputs are registered.
- Reset values:
  - `connect_corrected` = 0, `enemy_left_clicked` = 0, `enemy_right_clicked` = 0, `enemy_game_starts` = 0, `frame_error` = 0
  - `last_valid_byte` = 8'h00
  - State DISCONNECTED; all counters 0.
- Latency: the event in the `rx_valid` cycle N appears on the outputs in cycle N+1. Pulses last exactly one cycle.
- `connect_corrected` rises in cycle N+1 after the LOCK_COUNT-th valid byte in cycle N.
- Simultaneous `rx_valid` (valid byte) and timeout expiry: the byte wins. The counter clears and there is no disconnect.
- Simultaneous `rx_valid` (invalid byte) and timeout: the result is DISCONNECTED, and `frame_error` still pulses.
- Back-to-back `rx_valid` every cycle is supported with no dropped bytes.
- `rst` mid-operation returns everything to reset values on the next edge; pulses in flight are dropped.

## Configuration
- `SYNC_RX_DEDUP_EN`
  - Defined: a LEFT or RIGHT byte identical to the previous valid byte produces no pulse. A pulse is re-armed only after a different valid code (e.g. IDLE).
  - Undefined: every LEFT/RIGHT byte received in CONNECTED produces its pulse.
  - Link FSM and timeout behaviour are identical in both builds.

## Test plan
- Lock-up:
  - Stimulus: after reset, four 8'h08 bytes spaced 10 cycles apart.
  - Response: `connect_corrected` is 0 until 1 cycle after the 4th byte, then 1. No pulses.
- Decode:
  - Stimulus: once CONNECTED, send 8'hC8, 8'h28, 8'h48, 8'h08.
  - Response: one left pulse, one right pulse, then `enemy_game_starts` goes 1 and then back to 0. `last_valid_byte` ends at 8'h08.
- Error handling:
  - Stimulus: while CONNECTED, send 8'hFF, 8'h08, then 8'hFF three times.
  - Response: four `frame_error` pulses. The link stays up after the first 8'hFF and drops 1 cycle after the third consecutive 8'hFF.
- Timeout (TIMEOUT_CYCLES=100):
  - Stimulus: in CONNECTED with `enemy_game_starts`=1, stop all bytes.
  - Response: `connect_corrected` and `enemy_game_starts` fall after 100 cycles.
  - Stimulus: repeat with a valid byte arriving exactly at the expiry cycle.
  - Response: no drop.
- Dedup:
  - Stimulus: send 8'hC8, 8'hC8, 8'h08, 8'hC8.
  - Response with `SYNC_RX_DEDUP_EN`: 2 left pulses. Without it: 3.
- Reset:
  - Stimulus: assert `rst` mid-SYNCING after 2 valid bytes, then send 3 valid bytes.
  - Response: still not connected, since LOCK_COUNT restarts from 0.

Source files
------------

// File: rtl/sync_rx_decoder.sv
// Receive-side sync byte decoder: validates opponent sync codes, tracks link state and
// decodes click/start events. Optional SYNC_RX_DEDUP_EN suppresses repeated LEFT/RIGHT pulses.
module sync_rx_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned ERR_LIMIT      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       connect_corrected,
  output logic       enemy_left_clicked,
  output logic       enemy_right_clicked,
  output logic       enemy_game_starts,
  output logic       frame_error,
  output logic [7:0] last_valid_byte
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCK_COUNT);
  localparam logic [EW-1:0] ERR_END  = EW'(ERR_LIMIT);

  localparam logic [7:0] CODE_LEFT  = 8'hC8;
  localparam logic [7:0] CODE_RIGHT = 8'h28;
  localparam logic [7:0] CODE_START = 8'h48;
  localparam logic [7:0] CODE_IDLE  = 8'h08;

  typedef enum logic [1:0] {
    ST_DISC,
    ST_SYNC,
    ST_CONN
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
  logic [EW-1:0] err_cnt_q, err_cnt_d, err_inc;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          connect_q, connect_d;
  logic          left_q, left_d;
  logic          right_q, right_d;
  logic          start_q, start_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    last_q, last_d;

  logic code_ok, byte_ok, byte_bad, timeout, dup;

  always_comb begin
    code_ok  = (rx_data == CODE_LEFT) || (rx_data == CODE_RIGHT) ||
               (rx_data == CODE_START) || (rx_data == CODE_IDLE);
    byte_ok  = rx_valid && code_ok;
    byte_bad = rx_valid && !code_ok;
    timeout  = (to_cnt_q == TO_LAST);
    lock_inc = lock_cnt_q + LW'(1);
    err_inc  = err_cnt_q + EW'(1);
`ifdef SYNC_RX_DEDUP_EN
    dup = (rx_data == last_q);
`else
    dup = 1'b0;
`endif

    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    err_cnt_d  = err_cnt_q;
    left_d     = 1'b0;
    right_d    = 1'b0;
    start_d    = start_q;
    ferr_d     = byte_bad;
    last_d     = byte_ok ? rx_data : last_q;

    if (byte_ok)
      to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX)
      to_cnt_d = to_cnt_q + TW'(1);
    else
      to_cnt_d = to_cnt_q;

    // A valid byte always beats a coincident timeout; only its absence lets timeout act.
    case (state_q)
      ST_DISC: begin
        if (byte_ok) begin
          if (LOCK_COUNT <= 1) begin
            state_d    = ST_CONN;
            lock_cnt_d = '0;
            err_cnt_d  = '0;
          end else begin
            state_d    = ST_SYNC;
            lock_cnt_d = LW'(1);
          end
        end
      end
      ST_SYNC: begin
        if (byte_ok) begin
          if (lock_inc == LOCK_END) begin
            state_d    = ST_CONN;
            lock_cnt_d = '0;
            err_cnt_d  = '0;
          end else begin
            lock_cnt_d = lock_inc;
          end
        end else if (byte_bad || timeout) begin
          state_d    = ST_DISC;
          lock_cnt_d = '0;
        end
      end
      ST_CONN: begin
        if (byte_ok) begin
          err_cnt_d = '0;
          case (rx_data)
            CODE_LEFT: begin
              left_d  = !dup;
              start_d = 1'b0;
            end
            CODE_RIGHT: begin
              right_d = !dup;
              start_d = 1'b0;
            end
            CODE_START: start_d = 1'b1;
            default:    start_d = 1'b0;
          endcase
        end else begin
          if (byte_bad) begin
            if (err_inc == ERR_END) begin
              state_d   = ST_DISC;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_inc;
            end
          end
          if (timeout) begin
            state_d   = ST_DISC;
            err_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = ST_DISC;
        lock_cnt_d = '0;
        err_cnt_d  = '0;
      end
    endcase

    if (state_d != ST_CONN)
      start_d = 1'b0;
    connect_d = (state_d == ST_CONN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DISC;
      lock_cnt_q <= '0;
      err_cnt_q  <= '0;
      to_cnt_q   <= '0;
      connect_q  <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      start_q    <= 1'b0;
      ferr_q     <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      err_cnt_q  <= err_cnt_d;
      to_cnt_q   <= to_cnt_d;
      connect_q  <= connect_d;
      left_q     <= left_d;
      right_q    <= right_d;
      start_q    <= start_d;
      ferr_q     <= ferr_d;
      last_q     <= last_d;
    end
  end

  assign connect_corrected   = connect_q;
  assign enemy_left_clicked  = left_q;
  assign enemy_right_clicked = right_q;
  assign enemy_game_starts   = start_q;
  assign frame_error         = ferr_q;
  assign last_valid_byte     = last_q;

endmodule
